// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native valid/ready memory bus: widths,
// arbiter state encoding and the default error read data.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Read data handed back to a master whose transaction was cut off by the watchdog
    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage : mem_bus_pkg

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter in front of a single native-handshake
// memory port. The grant is locked for the whole transaction, and an
// optional watchdog completes transactions the slave never acknowledges.
module mem_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int unsigned        TIMEOUT   = 64,
    parameter logic [DATA_W-1:0]  ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_valid,
    input  logic              s_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              err,
    output logic              err_id
);

    // Watchdog counter width; kept at least one bit wide when the watchdog is disabled
    localparam int unsigned     TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TCNT_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              WD_EN     = (TIMEOUT > 0);

    // Round robin: a lone requester wins; on a tie the one not served last wins
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_id);
        return (v0 && v1) ? ~last_id : v1;
    endfunction

    arb_state_e        state_q;
    logic              gnt_q;
    logic              last_q;
    logic [TW-1:0]     tcnt_q;
    logic              err_q;
    logic              err_id_q;

    logic              busy_s;
    logic              ack_s;
    logic              timeout_s;
    logic              done_s;
    logic              gnt_d;
    logic [DATA_W-1:0] rsp_data_s;

    // Completion decode: a slave ack always wins over a simultaneous watchdog expiry
    always_comb begin
        busy_s     = (state_q == ST_BUSY);
        ack_s      = busy_s && s_ready;
        timeout_s  = WD_EN && busy_s && !s_ready && (tcnt_q == TCNT_LAST);
        done_s     = ack_s || timeout_s;
        gnt_d      = rr_pick(m0_valid, m1_valid, last_q);
        rsp_data_s = timeout_s ? ERR_RDATA : s_rdata;
    end

    // Master-side responses; only the granted master ever sees ready
    always_comb begin
        m0_ready = done_s && !gnt_q;
        m1_ready = done_s &&  gnt_q;
        m0_rdata = (!gnt_q) ? rsp_data_s : s_rdata;
        m1_rdata = ( gnt_q) ? rsp_data_s : s_rdata;
    end

    // Slave-side mux driven purely by the registered state and grant, zero when idle
    always_comb begin
        s_valid = busy_s;
        if (busy_s) begin
            s_addr  = gnt_q ? m1_addr  : m0_addr;
            s_wdata = gnt_q ? m1_wdata : m0_wdata;
            s_wstrb = gnt_q ? m1_wstrb : m0_wstrb;
        end else begin
            s_addr  = {ADDR_W{1'b0}};
            s_wdata = {DATA_W{1'b0}};
            s_wstrb = {STRB_W{1'b0}};
        end
    end

    assign err    = err_q;
    assign err_id = err_id_q;

    // Arbitration FSM with watchdog counter and error pulse/id registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
            err_id_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tcnt_q <= '0;
                    if (m0_valid || m1_valid) begin
                        gnt_q   <= gnt_d;
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        state_q <= ST_IDLE;
                        last_q  <= gnt_q;
                        tcnt_q  <= '0;
                        if (timeout_s) begin
                            err_q    <= 1'b1;
                            err_id_q <= gnt_q;
                        end else begin
                            err_id_q <= err_id_q;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1'b1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

endmodule : mem_arbiter2

// File: tb/tb_mem_arbiter2.sv
// Self-checking bench for mem_arbiter2: a transaction-level reference model
// compared every cycle, plus hand-computed expectations for the key scenarios.
module tb_mem_arbiter2;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic [3:0]  m0_wstrb = 4'd0, m1_wstrb = 4'd0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata, s_rdata = 32'd0;
    logic [3:0]  s_wstrb;
    logic        err, err_id;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mem_arbiter2 #(.TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .err(err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave memory model ----------------
    logic [31:0] mem [0:63];
    int          ack_lat     = 2;     // BUSY cycle index on which the slave acks; 0 = never
    logic        force_ready = 1'b0;  // stray ack while the arbiter is idle
    int          vcnt        = 0;

    always @(negedge clk) begin
        #1;
        if (s_valid === 1'b1) begin
            vcnt    = vcnt + 1;
            s_ready = (ack_lat != 0) && (vcnt == ack_lat);
            s_rdata = mem[s_addr[7:2]];
        end else begin
            vcnt    = 0;
            s_ready = force_ready;
            s_rdata = 32'h5A5A_0000 ^ cyc;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'd0;
            mem[4] = 32'h1234_5678;
        end else if (s_valid === 1'b1 && s_ready) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          chk_en = 0;
    bit          md_busy = 0, md_own = 0, md_last = 1, md_err = 0, md_err_id = 0;
    int          md_age = 0;
    int          served_q[$];
    int          ready_cyc[$];
    int          rise_q[$];
    logic        prev_sv = 1'b0;
    logic [3:0]  wstrb_seen = 4'd0;

    always @(negedge clk) begin
        bit fin_ack, fin_to, fin, v0, v1;
        logic [31:0] e_rd0, e_rd1;
        #3;
        if (chk_en) begin
            v0      = m0_valid;
            v1      = m1_valid;
            fin_ack = md_busy && s_ready;
            fin_to  = md_busy && !s_ready && (md_age == TO - 1);
            fin     = fin_ack || fin_to;
            e_rd0   = (fin_to && md_own == 0) ? 32'hDEAD_BEEF : s_rdata;
            e_rd1   = (fin_to && md_own == 1) ? 32'hDEAD_BEEF : s_rdata;

            chk("s_valid",  {31'd0, s_valid},  {31'd0, md_busy});
            chk("s_addr",   s_addr,  md_busy ? (md_own ? m1_addr  : m0_addr)  : 32'd0);
            chk("s_wdata",  s_wdata, md_busy ? (md_own ? m1_wdata : m0_wdata) : 32'd0);
            chk("s_wstrb",  {28'd0, s_wstrb}, {28'd0, md_busy ? (md_own ? m1_wstrb : m0_wstrb) : 4'd0});
            chk("m0_ready", {31'd0, m0_ready}, {31'd0, fin && md_own == 0});
            chk("m1_ready", {31'd0, m1_ready}, {31'd0, fin && md_own == 1});
            chk("m0_rdata", m0_rdata, e_rd0);
            chk("m1_rdata", m1_rdata, e_rd1);
            chk("err",      {31'd0, err},    {31'd0, md_err});
            chk("err_id",   {31'd0, err_id}, {31'd0, md_err_id});

            if (m0_ready === 1'b1) begin served_q.push_back(0); ready_cyc.push_back(cyc); end
            if (m1_ready === 1'b1) begin served_q.push_back(1); ready_cyc.push_back(cyc); end
            if (s_valid === 1'b1 && prev_sv !== 1'b1) rise_q.push_back(cyc);
            if (s_valid === 1'b1) wstrb_seen = s_wstrb;
            prev_sv = s_valid;

            if (rst) begin
                md_busy = 0; md_last = 1; md_err = 0; md_err_id = 0; md_age = 0; md_own = 0;
            end else if (md_busy) begin
                md_err = fin_to;
                if (fin) begin
                    md_busy = 0;
                    md_last = md_own;
                    if (fin_to) md_err_id = md_own;
                end else begin
                    md_age++;
                end
            end else begin
                md_err = 0;
                if (v0 || v1) begin
                    md_own  = (v0 && v1) ? !md_last : v1;
                    md_busy = 1;
                    md_age  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Must be called at a falling edge; returns at the falling edge after the drop of valid.
    task automatic req(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output int rc);
        rd = 32'd0;
        rc = -1;
        if (m == 0) begin m0_valid = 1; m0_addr = a; m0_wdata = wd; m0_wstrb = st; end
        else        begin m1_valid = 1; m1_addr = a; m1_wdata = wd; m1_wstrb = st; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #4;
            if (m == 0 && m0_ready === 1'b1) begin rd = m0_rdata; rc = cyc; break; end
            if (m == 1 && m1_ready === 1'b1) begin rd = m1_rdata; rc = cyc; break; end
        end
        if (rc < 0) chk("ready_wait", 32'd0, 32'd1);
        @(negedge clk);
        if (m == 0) m0_valid = 0; else m1_valid = 0;
    endtask

    task automatic clear_logs();
        served_q.delete();
        ready_cyc.delete();
        rise_q.delete();
    endtask

    initial begin
        logic [31:0] rd, rd1;
        int          rc, rc1, c0;

        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        #4;
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("rst_err", {30'd0, err, err_id}, 32'd0);
        @(negedge clk);
        rst = 0;

        // single read from m0
        clear_logs();
        c0 = cyc;
        req(0, 32'h10, 32'd0, 4'd0, rd, rc);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_latency", rc - c0, 32'd2);
        chk("rd_svalid_cyc", (rise_q.size() > 0) ? rise_q[0] - c0 : -1, 32'd1);
        chk("rd_only_m0", served_q.size(), 32'd1);

        // contention after reset, repeated: 0,1,0,1 with one idle gap
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        clear_logs();
        fork
            begin
                req(0, 32'h10, 32'd0, 4'd0, rd, rc);
                req(0, 32'h10, 32'd0, 4'd0, rd, rc);
            end
            begin
                req(1, 32'h10, 32'd0, 4'd0, rd1, rc1);
                req(1, 32'h10, 32'd0, 4'd0, rd1, rc1);
            end
        join
        chk("rr_count", served_q.size(), 32'd4);
        if (served_q.size() == 4) begin
            chk("rr_order", {served_q[0][7:0], served_q[1][7:0], served_q[2][7:0], served_q[3][7:0]},
                32'h0001_0001);
        end
        chk("rr_gap", (rise_q.size() > 1 && ready_cyc.size() > 0) ? rise_q[1] - ready_cyc[0] : -1, 32'd2);

        // byte write from m1, then read back
        wstrb_seen = 4'd0;
        req(1, 32'h20, 32'hAABB_CCDD, 4'b0100, rd, rc);
        chk("wr_strb", {28'd0, wstrb_seen}, 32'h4);
        req(1, 32'h20, 32'd0, 4'd0, rd, rc);
        chk("wr_readback", rd, 32'h00BB_0000);

        // watchdog: slave never acks
        ack_lat = 0;
        c0 = cyc;
        req(1, 32'h10, 32'd0, 4'd0, rd, rc);
        chk("to_rdata", rd, 32'hDEAD_BEEF);
        chk("to_latency", rc - c0, 32'd4);
        #4;
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_err_id", {31'd0, err_id}, 32'd1);
        @(negedge clk);
        force_ready = 1;
        #4;
        chk("late_ack_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
        chk("late_err_id_hold", {31'd0, err_id}, 32'd1);
        @(negedge clk);
        force_ready = 0;

        // reset in the middle of an m0 transaction
        clear_logs();
        m0_valid = 1; m0_addr = 32'h10; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        m0_valid = 0;
        #4;
        chk("rstmid_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rstmid_no_ready", served_q.size(), 32'd0);
        ack_lat = 2;
        @(negedge clk);
        fork
            req(0, 32'h10, 32'd0, 4'd0, rd, rc);
            req(1, 32'h20, 32'd0, 4'd0, rd1, rc1);
        join
        chk("rstmid_first_m0", (served_q.size() > 0) ? served_q[0] : -1, 32'd0);

        // slave ack coincides with watchdog expiry
        ack_lat = 4;
        c0 = cyc;
        req(0, 32'h10, 32'd0, 4'd0, rd, rc);
        chk("tie_rdata", rd, 32'h1234_5678);
        chk("tie_latency", rc - c0, 32'd4);
        #4;
        chk("tie_no_err", {31'd0, err}, 32'd0);
        ack_lat = 2;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, got running expected done");
        $fatal(1, "global timeout");
    end

endmodule : tb_mem_arbiter2

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
Two-requester arbiter that shares one native-handshake memory port (valid/ready, addr, wdata, wstrb, rdata) between two bus masters, e.g. a picorv32 core and a DMA/debug engine. It sits between the masters and the single-port memory. Arbitration is round-robin with the grant locked for a whole transaction. An optional watchdog terminates transactions the slave never acknowledges.

Parameters:
TIMEOUT, 64, slave-response watchdog in cycles counted in BUSY; 0 disables the watchdog
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timed-out transaction

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_valid  in  1  requester 0 request; held high until m0_ready
m0_ready  out  1  requester 0 completion, one-cycle pulse
m0_addr  in  32  requester 0 byte address
m0_wdata  in  32  requester 0 write data
m0_wstrb  in  4  requester 0 byte strobes; 0 means read
m0_rdata  out  32  requester 0 read data, valid while m0_ready
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same as m0_* for requester 1
s_valid  out  1  request to memory
s_ready  in  1  memory completion pulse
s_addr  out  32  muxed address
s_wdata  out  32  muxed write data
s_wstrb  out  4  muxed strobes
s_rdata  in  32  memory read data
err  out  1  one-cycle pulse when a transaction times out
err_id  out  1  requester id of the last timeout; holds its value until the next timeout

Behaviour:
- States: IDLE, BUSY. Registers: state, gnt (1b), last (1b), tcnt ($clog2(TIMEOUT+1) bits), err, err_id.
- Reset: state=IDLE, gnt=0, last=1 (so m0 wins the first tie), tcnt=0, err=0, err_id=0. All outputs inactive: s_valid=0, m*_ready=0, s_wstrb=0.
- IDLE, exactly one request: grant that requester, go to BUSY next cycle.
- IDLE, both requesting: grant !last.
- IDLE, no request: stay in IDLE.
- The grant is registered. No combinational valid-to-valid path exists.
- BUSY outputs:
  - s_valid=1.
  - s_addr/s_wdata/s_wstrb taken from the granted master.
  - s_valid does not depend on the master's valid. A master dropping valid in BUSY is a protocol violation; the transaction completes anyway.
- BUSY, s_ready=1:
  - Same cycle, combinational: m[gnt]_ready=1, m[gnt]_rdata=s_rdata.
  - Next edge: state=IDLE, last=gnt, tcnt=0.
- BUSY, TIMEOUT!=0 and tcnt==TIMEOUT-1 without s_ready:
  - Same cycle: m[gnt]_ready=1, m[gnt]_rdata=ERR_RDATA.
  - Next edge: err=1 for one cycle, err_id=gnt, state=IDLE, last=gnt.
  - Otherwise tcnt increments each BUSY cycle.
- s_ready and timeout in the same cycle: s_ready wins, no err.
- s_ready seen in IDLE (late slave ack after timeout or reset) is ignored. It produces no master ready.
- The non-granted master always sees ready=0. Its rdata reads s_rdata with no validity implied.
- Mux outputs in IDLE are s_addr=0, s_wdata=0, s_wstrb=0.
- Latency against a slave that acks one cycle after valid (the team's SRAM model): request seen in cycle 0, s_valid in cycle 1, m_ready in cycle 2.
- Back-to-back with the other master pending: the next grant is issued in the IDLE cycle after completion, so there is one idle cycle between slave transactions. This guarantees s_valid drops for at least one cycle, which the SRAM handshake requires.
- Reset asserted mid-transaction: next cycle state=IDLE and s_valid=0; no m_ready is issued for the aborted transaction.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE/BUSY);
  - the address, data and strobe width constants (32/32/4);
  - the default ERR_RDATA constant.
- No sub-module; the round-robin pick is a two-line function inside the block.

Test Plan:
- Single read: m0 reads 0x10 holding 0x12345678, m1 idle -> s_valid in cycle 1, m0_ready pulse in cycle 2 with m0_rdata=0x12345678, m1_ready stays 0.
- Contention after reset: m0 and m1 raise valid in the same cycle -> m0 is served first, then m1 gets s_valid two cycles after m0_ready (one IDLE cycle between). Repeating both requests continuously -> grants alternate 0,1,0,1.
- Byte write: m1 writes wdata=0xAABBCCDD with wstrb=4'b0100 to 0x20 holding 0 -> readback of 0x20 = 0x00BB0000; s_wstrb equals 4'b0100 only while BUSY.
- Timeout with TIMEOUT=4 and a slave that never acks: m1 read -> m1_ready in the 4th BUSY cycle with rdata=0xDEADBEEF, err pulses the next cycle with err_id=1. A later s_ready pulse in IDLE produces no m*_ready.
- Reset mid-transaction: assert rst during BUSY for m0 -> next cycle s_valid=0 and no m0_ready. After reset a simultaneous request is granted to m0.
- s_ready and timeout in the same cycle -> normal completion with s_rdata, err stays 0.
